sha256_host_ctrl: RTL and testbench
===================================

# sha256_host_ctrl

Host-side sequencer that drives `sha256_wrapper` from a 32-bit word stream. It packs pre-padded message words into 512-bit blocks and issues the IV/message/start controls. It waits out the core's busy period, then returns the 256-bit digest as eight 32-bit words on an output stream. It sits between the bus bridge or DMA and the SHA-256 wrapper, and it is the only initiator of the wrapper's control ports.

## Interface
Parameters:
- none

Ports:
- `io_mainClk` in 1 — system clock; all logic on the rising edge.
- `io_systemReset` in 1 — reset, synchronous, active-high.
- `s_data` in 32 — message word; the software has already applied SHA-256 padding.
- `s_valid` in 1 — `s_data` valid.
- `s_last` in 1 — final word of the final block of the message.
- `s_ready` out 1 — word accepted when `s_valid & s_ready`.
- `input_data_reg` out 512 — assembled block to the wrapper.
- `sha256_init_iv` out 1 — one-cycle pulse; core reloads IV (first block only).
- `sha256_init_message` out 1 — one-cycle pulse; core latches `input_data_reg`.
- `sha256_start` out 1 — one-cycle pulse; begin compression.
- `cmd_reg` out 3 — 3'b001 in the START cycle, 3'b000 otherwise.
- `module_busy` in 1 — core busy.
- `output_data` in 256 — core digest.
- `d_data` out 32 — digest word.
- `d_valid` out 1 — `d_data` valid.
- `d_last` out 1 — high with digest word 7.
- `d_ready` in 1 — digest word consumed when `d_valid & d_ready`.
- `err` out 1 — one-cycle pulse: `s_last` arrived on a word other than index 15.

## Operation
- State machine states: LOAD, IV, MSG, START, WAIT_HI, WAIT_LO, OUT.
- Internal state:
  - 4-bit word counter `wcnt`.
  - `first_blk` flag, 1 after reset.
  - `last_blk` flag.
  - 3-bit digest index `dcnt`.
- LOAD:
  - `s_ready` = 1.
  - Each accepted word is written to `input_data_reg[511-32*wcnt -: 32]`; the first word lands in bits [511:480].
  - `wcnt` increments and wraps 15→0.
  - On accepting word 15: `last_blk` ← `s_last`. Go to IV if `first_blk`, else MSG.
  - `s_last` with `wcnt` != 15:
    - `err` pulses and the block is discarded.
    - `wcnt` ← 0 and `first_blk` ← 1; the message is aborted.
    - Stay in LOAD. The word itself is not considered part of any message.
- IV: `sha256_init_iv` = 1 for one cycle; `first_blk` ← 0; go to MSG.
- MSG: `sha256_init_message` = 1 for one cycle; go to START.
- START: `sha256_start` = 1 and `cmd_reg` = 3'b001 for one cycle; go to WAIT_HI.
- WAIT_HI: go to WAIT_LO when `module_busy` = 1.
- WAIT_LO: when `module_busy` = 0, go to OUT if `last_blk`, else go to LOAD.
- OUT:
  - Snapshot `output_data` into a digest register on entry.
  - `d_valid` = 1 and `d_data` = `digest[255-32*dcnt -: 32]`.
  - `d_last` = (`dcnt` == 7).
  - On handshake, `dcnt` increments. After word 7, `dcnt` ← 0, `first_blk` ← 1, `last_blk` ← 0, and go to LOAD.
- `input_data_reg` holds its value outside LOAD writes. The core may re-read it at any time after MSG.
- The pulses `sha256_init_iv`, `sha256_init_message` and `sha256_start` are mutually exclusive and never overlap with `s_ready` = 1.

## Timing
- Reset value of every output:
  - `s_ready` = 0 while reset is high and 1 in the first cycle after reset.
  - `input_data_reg` = 0.
  - All pulse outputs = 0, `cmd_reg` = 0.
  - `d_valid` = 0, `d_last` = 0, `d_data` = 0, `err` = 0.
- All outputs are registered except `s_ready`, `d_data` and `d_last`, which are decoded from state and counters.
- Block latency, from the word-15 handshake (cycle T):
  - First block: IV at T+1, MSG at T+2, START at T+3.
  - Later blocks: MSG at T+1, START at T+2.
- WAIT_HI has no timeout. The core must assert `module_busy` within a bounded time after `sha256_start`.
- After `module_busy` falls (seen at cycle U): `d_valid` = 1 at U+1, or `s_ready` = 1 at U+1.
- `d_valid` stays high and `d_data` stays stable until `d_ready`. Throughput is one digest word per cycle.
- Reset mid-operation (any state): return to LOAD with `first_blk` = 1 next cycle, counters 0, `input_data_reg` = 0. Any in-progress digest is dropped.
- `s_valid` while not in LOAD: not accepted and no side effects.

## Test plan
- Single block "abc": send `61626380`, 14× `00000000`, `00000018`, with `s_last` on word 15.
  - Exactly one `sha256_init_iv` pulse.
  - Digest `ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad`, with `d_last` on word 7.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (padded, length `000001c0`):
  - Digest `248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1`.
  - `sha256_init_iv` is pulsed only once.
- Backpressure: run the "abc" case with `d_ready` toggling 1-0-0-1.
  - The same 8 words arrive in order.
  - `d_data` holds steady while stalled.
- Early `s_last` on word 5:
  - `err` pulses for one cycle and no `sha256_start` is issued.
  - A following "abc" message yields the correct digest.
- Reset during WAIT_LO:
  - Next cycle: state LOAD, `s_ready` = 1, all pulse outputs 0.
  - A subsequent "abc" message yields the correct digest.
- Idle `s_valid` during OUT and WAIT states: no word is accepted and `input_data_reg` is unchanged.

Source files
------------

// File: rtl/sha256_host_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_host_ctrl
//
// Host-side sequencer for the SHA-256 wrapper. Pre-padded 32-bit message
// words arrive on a valid/ready stream and are packed MSB-first into a
// 512-bit block. Once a block is complete the controller pulses the IV reload
// (first block of a message only), the message latch and the start strobe.
// It then waits for the core's busy period to begin and end. After the final
// block the 256-bit digest is returned as eight 32-bit words on an output
// valid/ready stream, word 0 being digest[255:224].
//
// Ports
//   io_mainClk           system clock, rising edge
//   io_systemReset       synchronous active-high reset
//   s_data/s_valid/s_last/s_ready
//                        message word stream (s_last = final word of message)
//   input_data_reg       assembled 512-bit block presented to the wrapper
//   sha256_init_iv       one-cycle pulse, core reloads its IV
//   sha256_init_message  one-cycle pulse, core latches input_data_reg
//   sha256_start         one-cycle pulse, core begins compression
//   cmd_reg              3'b001 during the start pulse, otherwise 0
//   module_busy          core busy indication
//   output_data          core digest
//   d_data/d_valid/d_last/d_ready
//                        digest word stream, d_last marks word 7
//   err                  one-cycle pulse when s_last arrives early
// ---------------------------------------------------------------------------
module sha256_host_ctrl (
    input  logic         io_mainClk,
    input  logic         io_systemReset,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [511:0] input_data_reg,
    output logic         sha256_init_iv,
    output logic         sha256_init_message,
    output logic         sha256_start,
    output logic [2:0]   cmd_reg,
    input  logic         module_busy,
    input  logic [255:0] output_data,
    output logic [31:0]  d_data,
    output logic         d_valid,
    output logic         d_last,
    input  logic         d_ready,
    output logic         err
);

    localparam logic [2:0] LOAD    = 3'd0;
    localparam logic [2:0] IV      = 3'd1;
    localparam logic [2:0] MSG     = 3'd2;
    localparam logic [2:0] START   = 3'd3;
    localparam logic [2:0] WAIT_HI = 3'd4;
    localparam logic [2:0] WAIT_LO = 3'd5;
    localparam logic [2:0] OUT     = 3'd6;

    logic [2:0]   state;
    logic [3:0]   wcnt;
    logic         first_blk;
    logic         last_blk;
    logic [2:0]   dcnt;
    logic [255:0] digest;
    logic         s_accept;

    // s_ready is decoded from state; it is forced low while reset is held so
    // no word can be taken in the reset cycle even if the state is stale.
    assign s_ready  = (state == LOAD) && !io_systemReset;
    assign s_accept = s_valid && s_ready;

    // Digest word selection: word 0 is the most significant 32 bits.
    assign d_data = d_valid ? digest[255 - 32*int'(dcnt) -: 32] : 32'd0;
    assign d_last = d_valid && (dcnt == 3'd7);

    // Main sequencer. The control pulses are registered and raised on the
    // transition into the state they belong to, so each pulse is high exactly
    // during the cycle the FSM occupies IV, MSG or START.
    always_ff @(posedge io_mainClk) begin
        if (io_systemReset) begin
            state               <= LOAD;
            wcnt                <= 4'd0;
            first_blk           <= 1'b1;
            last_blk            <= 1'b0;
            dcnt                <= 3'd0;
            digest              <= '0;
            input_data_reg      <= '0;
            sha256_init_iv      <= 1'b0;
            sha256_init_message <= 1'b0;
            sha256_start        <= 1'b0;
            cmd_reg             <= 3'b000;
            d_valid             <= 1'b0;
            err                 <= 1'b0;
        end else begin
            sha256_init_iv      <= 1'b0;
            sha256_init_message <= 1'b0;
            sha256_start        <= 1'b0;
            cmd_reg             <= 3'b000;
            err                 <= 1'b0;

            case (state)
                LOAD: begin
                    if (s_accept) begin
                        if (s_last && (wcnt != 4'd15)) begin
                            // Early s_last: abort the whole message; the
                            // offending word is not stored anywhere.
                            err       <= 1'b1;
                            wcnt      <= 4'd0;
                            first_blk <= 1'b1;
                        end else begin
                            input_data_reg[511 - 32*int'(wcnt) -: 32] <= s_data;
                            wcnt <= wcnt + 4'd1;
                            if (wcnt == 4'd15) begin
                                last_blk <= s_last;
                                if (first_blk) begin
                                    state          <= IV;
                                    sha256_init_iv <= 1'b1;
                                end else begin
                                    state               <= MSG;
                                    sha256_init_message <= 1'b1;
                                end
                            end
                        end
                    end
                end

                IV: begin
                    first_blk           <= 1'b0;
                    state               <= MSG;
                    sha256_init_message <= 1'b1;
                end

                MSG: begin
                    state        <= START;
                    sha256_start <= 1'b1;
                    cmd_reg      <= 3'b001;
                end

                START: begin
                    state <= WAIT_HI;
                end

                // The core needs a cycle or more to raise busy; waiting for
                // the rising edge first keeps us from mistaking the idle low
                // level for completion.
                WAIT_HI: begin
                    if (module_busy) begin
                        state <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!module_busy) begin
                        if (last_blk) begin
                            state   <= OUT;
                            digest  <= output_data;
                            d_valid <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                OUT: begin
                    if (d_ready) begin
                        if (dcnt == 3'd7) begin
                            dcnt      <= 3'd0;
                            first_blk <= 1'b1;
                            last_blk  <= 1'b0;
                            d_valid   <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            dcnt <= dcnt + 3'd1;
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_host_ctrl
//
// Bench for sha256_host_ctrl. A behavioural SHA-256 wrapper model answers the
// control pulses with random busy periods. A reference model computes, from
// the accepted words alone, the expected block register, pulse cycles,
// stream readiness and digest. It is compared against the DUT every cycle.
// Known digests for "abc" and the 448-bit two-block message pin the model.
// ---------------------------------------------------------------------------
module tb_sha256_host_ctrl;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         io_mainClk = 1'b0;
    logic         io_systemReset = 1'b1;
    logic [31:0]  s_data = 32'd0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [511:0] input_data_reg;
    logic         sha256_init_iv;
    logic         sha256_init_message;
    logic         sha256_start;
    logic [2:0]   cmd_reg;
    logic         module_busy = 1'b0;
    logic [255:0] output_data = '0;
    logic [31:0]  d_data;
    logic         d_valid;
    logic         d_last;
    logic         d_ready = 1'b0;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    sha256_host_ctrl dut (
        .io_mainClk          (io_mainClk),
        .io_systemReset      (io_systemReset),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_last              (s_last),
        .s_ready             (s_ready),
        .input_data_reg      (input_data_reg),
        .sha256_init_iv      (sha256_init_iv),
        .sha256_init_message (sha256_init_message),
        .sha256_start        (sha256_start),
        .cmd_reg             (cmd_reg),
        .module_busy         (module_busy),
        .output_data         (output_data),
        .d_data              (d_data),
        .d_valid             (d_valid),
        .d_last              (d_last),
        .d_ready             (d_ready),
        .err                 (err)
    );

    always #5 io_mainClk = ~io_mainClk;

    // Plain SHA-256 compression of one 512-bit block onto a chaining value.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %0h required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Wrapper model: reacts to the control pulses, raises busy after 1-3
    // cycles for a random length and publishes the new chaining value as busy
    // falls. It shares the system reset.
    int force_hold = 0;
    initial begin
        logic [255:0] core_h;
        logic [511:0] core_blk;
        int wstage, pre, hold;
        core_h = '0; core_blk = '0; wstage = 0; pre = 0; hold = 0;
        forever begin
            @(posedge io_mainClk);
            #2;
            if (io_systemReset) begin
                wstage = 0;
                module_busy = 1'b0;
            end else begin
                if (sha256_init_iv) core_h = SHA_IV;
                if (sha256_init_message) core_blk = input_data_reg;
                if (sha256_start) begin
                    wstage = 1;
                    pre = $urandom_range(0, 2);
                end else if (wstage == 1) begin
                    if (pre == 0) begin
                        module_busy = 1'b1;
                        hold = (force_hold > 0) ? force_hold : $urandom_range(1, 5);
                        wstage = 2;
                    end else begin
                        pre--;
                    end
                end else if (wstage == 2) begin
                    hold--;
                    if (hold == 0) begin
                        core_h = compress(core_h, core_blk);
                        output_data = core_h;
                        module_busy = 1'b0;
                        wstage = 0;
                    end
                end
            end
        end
    end

    // Digest-side consumer: always ready, a fixed 1-0-0-1 pattern, or random.
    int rdy_mode = 0;
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge io_mainClk);
            #1;
            case (rdy_mode)
                0: d_ready = 1'b1;
                1: d_ready = pat[k % 4];
                default: d_ready = 1'($urandom_range(0, 1));
            endcase
            k++;
        end
    end

    // Reference model and per-cycle comparison. phase: 0 loading words,
    // 1 block handed to the core, 2 digest being returned.
    int cyc = 0;
    int phase, widx, didx;
    int exp_iv, exp_msg, exp_start, exp_err;
    int iv_count = 0, start_count = 0, err_count = 0, digests_done = 0;
    bit m_first, m_last, seen_busy, prev_rst;
    logic [511:0] m_reg;
    logic [255:0] m_h, m_dig;
    logic [31:0] rx [8];

    initial begin
        phase = 0; widx = 0; didx = 0; m_first = 1; m_last = 0; seen_busy = 0; prev_rst = 1;
        exp_iv = -1; exp_msg = -1; exp_start = -1; exp_err = -1;
        m_reg = '0; m_h = '0; m_dig = '0;
        forever begin
            @(negedge io_mainClk);
            cyc++;
            if (io_systemReset) begin
                checkOutput("s_ready_in_reset", 512'(s_ready), 512'(0));
                phase = 0; widx = 0; didx = 0; m_first = 1; m_last = 0; m_reg = '0;
                exp_iv = -1; exp_msg = -1; exp_start = -1; exp_err = -1;
                prev_rst = 1;
            end else begin
                if (prev_rst) begin
                    checkOutput("reset_input_data_reg", input_data_reg, 512'(0));
                    checkOutput("reset_d_data", 512'(d_data), 512'(0));
                    prev_rst = 0;
                end
                checkOutput("s_ready", 512'(s_ready), 512'(phase == 0));
                checkOutput("init_iv", 512'(sha256_init_iv), 512'(cyc == exp_iv));
                checkOutput("init_message", 512'(sha256_init_message), 512'(cyc == exp_msg));
                checkOutput("start", 512'(sha256_start), 512'(cyc == exp_start));
                checkOutput("cmd_reg", 512'(cmd_reg), 512'((cyc == exp_start) ? 1 : 0));
                checkOutput("err", 512'(err), 512'(cyc == exp_err));
                if (phase != 0) checkOutput("input_data_reg", input_data_reg, m_reg);
                if (phase == 2) begin
                    checkOutput("d_valid", 512'(d_valid), 512'(1));
                    checkOutput("d_data", 512'(d_data), 512'(m_dig[255 - 32*didx -: 32]));
                    checkOutput("d_last", 512'(d_last), 512'(didx == 7));
                end else begin
                    checkOutput("d_valid_idle", 512'(d_valid), 512'(0));
                    checkOutput("d_last_idle", 512'(d_last), 512'(0));
                end
                if (sha256_init_iv) iv_count++;
                if (sha256_start) start_count++;
                if (err) err_count++;

                case (phase)
                    0: begin
                        if (s_valid) begin
                            if (s_last && widx != 15) begin
                                exp_err = cyc + 1;
                                widx = 0;
                                m_first = 1;
                            end else begin
                                m_reg[511 - 32*widx -: 32] = s_data;
                                if (widx == 15) begin
                                    m_h = compress(m_first ? SHA_IV : m_h, m_reg);
                                    m_last = s_last;
                                    if (m_last) m_dig = m_h;
                                    if (m_first) begin
                                        exp_iv = cyc + 1; exp_msg = cyc + 2; exp_start = cyc + 3;
                                    end else begin
                                        exp_msg = cyc + 1; exp_start = cyc + 2;
                                    end
                                    m_first = 0;
                                    seen_busy = 0;
                                    widx = 0;
                                    phase = 1;
                                end else begin
                                    widx++;
                                end
                            end
                        end
                    end
                    1: begin
                        if (cyc > exp_start) begin
                            if (seen_busy && !module_busy) begin
                                phase = m_last ? 2 : 0;
                                didx = 0;
                            end
                            if (module_busy) seen_busy = 1;
                        end
                    end
                    default: begin
                        if (d_ready) begin
                            rx[didx] = d_data;
                            if (didx == 7) begin
                                phase = 0;
                                m_first = 1;
                                m_last = 0;
                                digests_done++;
                            end else begin
                                didx++;
                            end
                        end
                    end
                endcase
            end
        end
    end

    logic [31:0] words [32];

    task automatic sendWord(input logic [31:0] data, input logic last);
        int t;
        s_valid = 1'b1;
        s_data = data;
        s_last = last;
        t = 0;
        forever begin
            @(negedge io_mainClk);
            if (s_ready) break;
            t++;
            if (t > 4000) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL s_ready_timeout: actual 0 required 1");
                break;
            end
        end
        @(posedge io_mainClk);
        #1;
    endtask

    // Sends words[0..n-1] with s_last on word last_idx and random idle gaps.
    task automatic applyStimulus(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge io_mainClk);
                #1;
            end
            sendWord(words[i], 1'(i == last_idx));
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic waitDigest(input int target);
        int t;
        t = 0;
        while (digests_done < target && t < 4000) begin
            @(posedge io_mainClk);
            t++;
        end
        #1;
        checkOutput("digest_count", 512'(digests_done), 512'(target));
    endtask

    task automatic checkDigest(input string name, input logic [255:0] expv);
        for (int i = 0; i < 8; i++) checkOutput(name, 512'(rx[i]), 512'(expv[255 - 32*i -: 32]));
    endtask

    task automatic loadAbc();
        for (int i = 0; i < 32; i++) words[i] = 32'd0;
        words[0] = 32'h61626380;
        words[15] = 32'h00000018;
    endtask

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done, starts_before, errs_before, t, nblk;
        logic [31:0] two_words [16];
        two_words = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        done = 0;

        repeat (3) @(posedge io_mainClk);
        #1;
        io_systemReset = 1'b0;
        repeat (2) @(posedge io_mainClk);
        #1;

        $display("[TB] single block abc");
        iv_count = 0;
        loadAbc();
        applyStimulus(16, 15);
        done++;
        waitDigest(done);
        checkDigest("abc_digest", ABC_DIGEST);
        checkOutput("abc_iv_count", 512'(iv_count), 512'(1));

        $display("[TB] two block message");
        iv_count = 0;
        starts_before = start_count;
        for (int i = 0; i < 32; i++) words[i] = 32'd0;
        for (int i = 0; i < 16; i++) words[i] = two_words[i];
        words[31] = 32'h000001c0;
        applyStimulus(32, 31);
        done++;
        waitDigest(done);
        checkDigest("two_block_digest", TWO_DIGEST);
        checkOutput("two_block_iv_count", 512'(iv_count), 512'(1));
        checkOutput("two_block_starts", 512'(start_count - starts_before), 512'(2));

        $display("[TB] abc with d_ready backpressure");
        rdy_mode = 1;
        loadAbc();
        applyStimulus(16, 15);
        done++;
        waitDigest(done);
        checkDigest("backpressure_digest", ABC_DIGEST);
        rdy_mode = 0;

        $display("[TB] early s_last on word 5");
        starts_before = start_count;
        errs_before = err_count;
        loadAbc();
        applyStimulus(6, 5);
        repeat (20) @(posedge io_mainClk);
        #1;
        checkOutput("early_last_err_count", 512'(err_count - errs_before), 512'(1));
        checkOutput("early_last_no_start", 512'(start_count - starts_before), 512'(0));
        loadAbc();
        applyStimulus(16, 15);
        done++;
        waitDigest(done);
        checkDigest("after_err_digest", ABC_DIGEST);

        $display("[TB] reset during WAIT_LO");
        force_hold = 4;
        loadAbc();
        applyStimulus(16, 15);
        t = 0;
        while (!module_busy && t < 100) begin
            @(negedge io_mainClk);
            t++;
        end
        checkOutput("busy_seen", 512'(module_busy), 512'(1));
        @(posedge io_mainClk);
        #1;
        io_systemReset = 1'b1;
        @(posedge io_mainClk);
        #1;
        io_systemReset = 1'b0;
        force_hold = 0;
        @(negedge io_mainClk);
        checkOutput("post_reset_s_ready", 512'(s_ready), 512'(1));
        checkOutput("post_reset_pulses",
                    512'({sha256_init_iv, sha256_init_message, sha256_start, err, d_valid}), 512'(0));
        @(posedge io_mainClk);
        #1;
        loadAbc();
        applyStimulus(16, 15);
        done++;
        waitDigest(done);
        checkDigest("after_reset_digest", ABC_DIGEST);

        $display("[TB] random back-to-back messages");
        rdy_mode = 2;
        for (int m = 0; m < 6; m++) begin
            nblk = $urandom_range(1, 2);
            for (int i = 0; i < 32; i++) words[i] = $urandom;
            applyStimulus(16 * nblk, 16 * nblk - 1);
            done++;
        end
        waitDigest(done);

        repeat (5) @(posedge io_mainClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
